// File: rtl/convert_outputs.sv
// Output converter for the FP add/sub datapath: narrows a double result to single
// precision with IEEE rounding (or passes it through) behind a 2-stage valid/ready pipe.
module convert_outputs #(
    parameter int NONE_PIPE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [63:0] result_in,
    input  logic        P,
    input  logic [1:0]  rm,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [63:0] result_out,
    output logic [3:0]  flags_out
);

    typedef struct packed {
        logic        sign;
        logic        is_zero;
        logic        is_den;
        logic        is_inf;
        logic        is_qnan;
        logic        is_snan;
        logic        is_norm;
        logic [11:0] e_s;
        logic [22:0] f_k;
        logic        g;
        logic        s;
        logic        inc;
        logic        p;
        logic [1:0]  rm;
        logic [63:0] raw;
    } s1_t;

    localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;

    s1_t         s1_d_s;
    s1_t         s1_q_s;
    logic        s1_valid_s;
    logic        s1_adv_s;
    logic [23:0] m_s;
    logic [11:0] e_f_s;
    logic [31:0] sp_s;
    logic [63:0] res_s;
    logic [3:0]  flg_s;

    assign s1_adv_s = ~valid_out | ready_out;

    // Stage-1 decode: classify the double and precompute SP exponent and rounding increment
    always_comb begin
        s1_d_s         = '0;
        s1_d_s.sign    = result_in[63];
        s1_d_s.is_zero = (result_in[62:52] == 11'd0)     && (result_in[51:0] == 52'd0);
        s1_d_s.is_den  = (result_in[62:52] == 11'd0)     && (result_in[51:0] != 52'd0);
        s1_d_s.is_inf  = (result_in[62:52] == 11'h7FF)   && (result_in[51:0] == 52'd0);
        s1_d_s.is_qnan = (result_in[62:52] == 11'h7FF)   && result_in[51];
        s1_d_s.is_snan = (result_in[62:52] == 11'h7FF)   && !result_in[51] && (result_in[50:0] != 51'd0);
        s1_d_s.is_norm = (result_in[62:52] != 11'd0)     && (result_in[62:52] != 11'h7FF);
        s1_d_s.e_s     = {1'b0, result_in[62:52]} - 12'd896;
        s1_d_s.f_k     = result_in[51:29];
        s1_d_s.g       = result_in[28];
        s1_d_s.s       = |result_in[27:0];
        s1_d_s.p       = P;
        s1_d_s.rm      = rm;
        s1_d_s.raw     = result_in;
        case (rm)
            2'b00:   s1_d_s.inc = result_in[28] & ((|result_in[27:0]) | result_in[29]);
            2'b01:   s1_d_s.inc = 1'b0;
            2'b10:   s1_d_s.inc = (result_in[28] | (|result_in[27:0])) & ~result_in[63];
            2'b11:   s1_d_s.inc = (result_in[28] | (|result_in[27:0])) & result_in[63];
            default: s1_d_s.inc = 1'b0;
        endcase
    end

    generate
        if (NONE_PIPE == 0) begin : g_s1_reg
            logic s1_valid_r;
            s1_t  s1_q_r;

            // Stage-1 register: loads whenever the stage is empty or stage 2 takes its contents
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    s1_valid_r <= 1'b0;
                    s1_q_r     <= '0;
                end else if (ready_in) begin
                    s1_valid_r <= valid_in;
                    if (valid_in) begin
                        s1_q_r <= s1_d_s;
                    end
                end
            end

            assign s1_valid_s = s1_valid_r;
            assign s1_q_s     = s1_q_r;
            assign ready_in   = ~s1_valid_r | s1_adv_s;
        end else begin : g_s1_comb
            assign s1_valid_s = valid_in;
            assign s1_q_s     = s1_d_s;
            assign ready_in   = s1_adv_s;
        end
    endgenerate

    // Stage-2 pack: round, detect overflow/flush and build the packed word and flags
    always_comb begin
        m_s   = {1'b0, s1_q_s.f_k} + {23'd0, s1_q_s.inc};
        e_f_s = s1_q_s.e_s + {11'd0, m_s[23]};
        sp_s  = 32'd0;
        flg_s = 4'd0;
        res_s = 64'd0;
        if (!s1_q_s.p) begin
            res_s = s1_q_s.raw;
        end else begin
            if (s1_q_s.is_zero) begin
                sp_s = {s1_q_s.sign, 31'd0};
            end else if (s1_q_s.is_inf) begin
                sp_s = {s1_q_s.sign, 8'hFF, 23'd0};
            end else if (s1_q_s.is_qnan || s1_q_s.is_snan) begin
                sp_s     = SP_QNAN;
                flg_s[3] = s1_q_s.is_snan;
            end else if (s1_q_s.is_den || ($signed(s1_q_s.e_s) <= $signed(12'd0))) begin
                sp_s  = {s1_q_s.sign, 31'd0};
                flg_s = 4'b0011;
            end else if ($signed(e_f_s) >= $signed(12'd255)) begin
                flg_s = 4'b0101;
                // Directed modes saturate to max-finite on the side they round away from
                case (s1_q_s.rm)
                    2'b00:   sp_s = {s1_q_s.sign, 8'hFF, 23'd0};
                    2'b01:   sp_s = {s1_q_s.sign, 31'h7F7F_FFFF};
                    2'b10:   sp_s = s1_q_s.sign ? {1'b1, 31'h7F7F_FFFF} : {1'b0, 8'hFF, 23'd0};
                    2'b11:   sp_s = s1_q_s.sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, 31'h7F7F_FFFF};
                    default: sp_s = {s1_q_s.sign, 8'hFF, 23'd0};
                endcase
            end else begin
                sp_s     = {s1_q_s.sign, e_f_s[7:0], m_s[22:0]};
                flg_s[0] = s1_q_s.g | s1_q_s.s;
            end
            res_s = {sp_s, 32'd0};
        end
    end

    // Stage-2 / output register: holds while downstream stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_out  <= 1'b0;
            result_out <= 64'd0;
            flags_out  <= 4'd0;
        end else if (s1_adv_s) begin
            valid_out <= s1_valid_s;
            if (s1_valid_s) begin
                result_out <= res_s;
                flags_out  <= flg_s;
            end
        end
    end

endmodule

// File: tb/tb_convert_outputs.sv
// Directed self-checking bench for convert_outputs: conversion vectors, backpressure, reset mid-stream.
module tb_convert_outputs;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        ready_in;
    logic [63:0] result_in;
    logic        P;
    logic [1:0]  rm;
    logic        valid_out;
    logic        ready_out;
    logic [63:0] result_out;
    logic [3:0]  flags_out;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam int NV = 24;
    logic [63:0] v_in  [NV];
    logic        v_p   [NV];
    logic [1:0]  v_rm  [NV];
    logic [63:0] v_res [NV];
    logic [3:0]  v_flg [NV];

    convert_outputs dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .result_in  (result_in),
        .P          (P),
        .rm         (rm),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .result_out (result_out),
        .flags_out  (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic p, input logic [1:0] r, input logic [63:0] din,
                           input logic [63:0] dres, input logic [3:0] dflg);
        v_p[i] = p; v_rm[i] = r; v_in[i] = din; v_res[i] = dres; v_flg[i] = dflg;
    endtask

    initial begin
        set_vec( 0, 1'b1, 2'b00, 64'h3FF0000000000000, 64'h3F80000000000000, 4'b0000);
        set_vec( 1, 1'b1, 2'b00, 64'h3FF0000010000000, 64'h3F80000000000000, 4'b0001);
        set_vec( 2, 1'b1, 2'b00, 64'h3FF0000010000001, 64'h3F80000100000000, 4'b0001);
        set_vec( 3, 1'b1, 2'b01, 64'h7E37E43C8800759C, 64'h7F7FFFFF00000000, 4'b0101);
        set_vec( 4, 1'b1, 2'b00, 64'h7E37E43C8800759C, 64'h7F80000000000000, 4'b0101);
        set_vec( 5, 1'b1, 2'b00, 64'h47EFFFFFF0000000, 64'h7F80000000000000, 4'b0101);
        set_vec( 6, 1'b1, 2'b00, 64'h7FF0000000000001, 64'h7FC0000000000000, 4'b1000);
        set_vec( 7, 1'b1, 2'b00, 64'h3800000000000000, 64'h0000000000000000, 4'b0011);
        set_vec( 8, 1'b0, 2'b00, 64'h7FF0000000000001, 64'h7FF0000000000001, 4'b0000);
        set_vec( 9, 1'b0, 2'b01, 64'h3FF0000010000001, 64'h3FF0000010000001, 4'b0000);
        set_vec(10, 1'b1, 2'b10, 64'hFE37E43C8800759C, 64'hFF7FFFFF00000000, 4'b0101);
        set_vec(11, 1'b1, 2'b11, 64'hFE37E43C8800759C, 64'hFF80000000000000, 4'b0101);
        set_vec(12, 1'b1, 2'b11, 64'h7E37E43C8800759C, 64'h7F7FFFFF00000000, 4'b0101);
        set_vec(13, 1'b1, 2'b10, 64'h7E37E43C8800759C, 64'h7F80000000000000, 4'b0101);
        set_vec(14, 1'b1, 2'b00, 64'h8000000000000000, 64'h8000000000000000, 4'b0000);
        set_vec(15, 1'b1, 2'b00, 64'hFFF0000000000000, 64'hFF80000000000000, 4'b0000);
        set_vec(16, 1'b1, 2'b00, 64'h7FF8000000000000, 64'h7FC0000000000000, 4'b0000);
        set_vec(17, 1'b1, 2'b00, 64'h8000000000000001, 64'h8000000000000000, 4'b0011);
        set_vec(18, 1'b1, 2'b10, 64'h3FF0000000000001, 64'h3F80000100000000, 4'b0001);
        set_vec(19, 1'b1, 2'b11, 64'h3FF0000000000001, 64'h3F80000000000000, 4'b0001);
        set_vec(20, 1'b1, 2'b11, 64'hBFF0000000000001, 64'hBF80000100000000, 4'b0001);
        set_vec(21, 1'b1, 2'b00, 64'h3FF0000030000000, 64'h3F80000200000000, 4'b0001);
        set_vec(22, 1'b1, 2'b00, 64'h3810000000000000, 64'h0080000000000000, 4'b0000);
        set_vec(23, 1'b1, 2'b01, 64'h47EFFFFFF0000000, 64'h7F7FFFFF00000000, 4'b0001);

        reset_n   = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        result_in = 64'd0;
        P         = 1'b0;
        rm        = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid_out", {63'd0, valid_out}, 64'd0);
        check_val("rst_result", result_out, 64'd0);
        check_val("rst_flags", {60'd0, flags_out}, 64'd0);
        check_val("rst_ready_in", {63'd0, ready_in}, 64'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            P         = v_p[i];
            rm        = v_rm[i];
            result_in = v_in[i];
            valid_in  = 1'b1;
            check_val($sformatf("v%0d_ready_in", i), {63'd0, ready_in}, 64'd1);
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            check_val($sformatf("v%0d_lat1_valid", i), {63'd0, valid_out}, 64'd0);
            @(posedge clk);
            #1;
            check_val($sformatf("v%0d_lat2_valid", i), {63'd0, valid_out}, 64'd1);
            check_val($sformatf("v%0d_result", i), result_out, v_res[i]);
            check_val($sformatf("v%0d_flags", i), {60'd0, flags_out}, {60'd0, v_flg[i]});
        end
        @(posedge clk);
        #1;

        // Backpressure: three back-to-back inputs while downstream stalls
        ready_out = 1'b0;
        P         = 1'b0;
        rm        = 2'b00;
        result_in = 64'h1111111111111111;
        valid_in  = 1'b1;
        check_val("bp_rdy_a", {63'd0, ready_in}, 64'd1);
        @(posedge clk);
        #1;
        result_in = 64'h2222222222222222;
        check_val("bp_rdy_b", {63'd0, ready_in}, 64'd1);
        @(posedge clk);
        #1;
        result_in = 64'h3333333333333333;
        check_val("bp_rdy_full", {63'd0, ready_in}, 64'd0);
        check_val("bp_valid_a", {63'd0, valid_out}, 64'd1);
        check_val("bp_result_a", result_out, 64'h1111111111111111);
        @(posedge clk);
        #1;
        check_val("bp_rdy_still", {63'd0, ready_in}, 64'd0);
        check_val("bp_hold_a", result_out, 64'h1111111111111111);
        ready_out = 1'b1;
        #1;
        check_val("bp_rdy_release", {63'd0, ready_in}, 64'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check_val("bp_valid_b", {63'd0, valid_out}, 64'd1);
        check_val("bp_result_b", result_out, 64'h2222222222222222);
        @(posedge clk);
        #1;
        check_val("bp_valid_c", {63'd0, valid_out}, 64'd1);
        check_val("bp_result_c", result_out, 64'h3333333333333333);
        @(posedge clk);
        #1;
        check_val("bp_drained", {63'd0, valid_out}, 64'd0);

        // Reset with both stages full
        ready_out = 1'b0;
        P         = 1'b1;
        result_in = 64'h3FF0000000000000;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        result_in = 64'h4000000000000000;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check_val("mr_full_rdy", {63'd0, ready_in}, 64'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("mr_valid_out", {63'd0, valid_out}, 64'd0);
        check_val("mr_ready_in", {63'd0, ready_in}, 64'd1);
        check_val("mr_result", result_out, 64'd0);
        check_val("mr_flags", {60'd0, flags_out}, 64'd0);
        reset_n   = 1'b1;
        ready_out = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("mr_no_stale%0d", k), {63'd0, valid_out}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
